// File: rtl/mem_wb_unit.sv
// -----------------------------------------------------------------------------
// mem_wb_unit
//
// Memory-access and writeback end of the ARM pipeline. EX/MEM results arrive
// on ex_*; loads and stores go to data memory over a req/ack handshake while
// 'freeze' stalls the upstream stages. The MEM/WB register drives the
// writeback bus consumed by the ID-stage register file.
//
// Parameters
//   BASE_ADDR : byte address subtracted from the ALU result before word addressing
//   TIMEOUT   : maximum BUSY cycles to wait for mem_ack before abandoning
//   CNT_W     : timeout counter width, 2**CNT_W must exceed TIMEOUT
//
// Ports
//   clk, rst                : clock (rising edge), asynchronous active-low reset
//   ex_wb_en, ex_mem_r_en,
//   ex_mem_w_en             : register write / load / store request from EX/MEM
//   ex_alu_res, ex_val_rm   : byte address (or ALU result) and store data
//   ex_dest                 : destination register
//   mem_ack, mem_rdata      : memory completion and load data
//   mem_req, mem_we,
//   mem_addr, mem_wdata     : memory request, write strobe, word address, data
//   freeze                  : upstream stall
//   err                     : sticky timeout flag
//   WB_WB_EN, WBDest,
//   WBValue                 : writeback bus to the register file
// -----------------------------------------------------------------------------
module mem_wb_unit #(
  parameter int unsigned BASE_ADDR = 1024,
  parameter int unsigned TIMEOUT   = 16,
  parameter int unsigned CNT_W     = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_wb_en,
  input  logic        ex_mem_r_en,
  input  logic        ex_mem_w_en,
  input  logic [31:0] ex_alu_res,
  input  logic [31:0] ex_val_rm,
  input  logic [3:0]  ex_dest,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        freeze,
  output logic        err,
  output logic        WB_WB_EN,
  output logic [3:0]  WBDest,
  output logic [31:0] WBValue
);

  localparam logic [31:0]      BASE_W   = 32'(BASE_ADDR);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Access FSM state
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             abandon_q, abandon_d;
  logic [31:0]      rdata_buf_q, rdata_buf_d;

  // MEM/WB pipeline register
  logic             wb_en_q, wb_en_d;
  logic             mem_r_en_q, mem_r_en_d;
  logic [31:0]      alu_res_q, alu_res_d;
  logic [3:0]       dest_q, dest_d;

  logic             memop_s;
  logic             bubble_s;
  logic [31:0]      addr_off_s;

  assign memop_s    = ex_mem_r_en | ex_mem_w_en;
  // Wrap-around below BASE_ADDR is deliberately left unchecked.
  assign addr_off_s = ex_alu_res - BASE_W;

  // FSM state register and access bookkeeping
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      abandon_q   <= 1'b0;
      rdata_buf_q <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      abandon_q   <= abandon_d;
      rdata_buf_q <= rdata_buf_d;
    end
  end

  // FSM next-state: start on memop in IDLE, wait for ack or timeout in BUSY
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    abandon_d   = abandon_q;
    rdata_buf_d = rdata_buf_q;
    case (state_q)
      S_IDLE: begin
        if (memop_s) begin
          state_d   = S_BUSY;
          cnt_d     = '0;
          abandon_d = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        if (mem_ack) begin
          rdata_buf_d = mem_rdata;
          abandon_d   = 1'b0;
          state_d     = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          // Give up on the access; the writeback slot becomes a bubble.
          err_d     = 1'b1;
          abandon_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_DONE: begin
        // The held ex_* op is the one just completed, so never restart here.
        state_d = S_IDLE;
      end
      default: begin
        state_d   = S_IDLE;
        cnt_d     = '0;
        abandon_d = 1'b0;
      end
    endcase
  end

  // FSM outputs: memory port and upstream stall
  always_comb begin
    mem_req = (state_q == S_BUSY);
    // Stall is gated by reset so a held memop cannot freeze the pipe in reset.
    if (!rst) begin
      freeze = 1'b0;
    end else begin
      freeze = ((state_q == S_IDLE) & memop_s) | (state_q == S_BUSY);
    end
    // Port fields are only meaningful while requesting; park them at zero.
    if (mem_req) begin
      mem_we    = ex_mem_w_en & ~ex_mem_r_en;
      mem_addr  = addr_off_s >> 2;
      mem_wdata = ex_val_rm;
    end else begin
      mem_we    = 1'b0;
      mem_addr  = 32'h0000_0000;
      mem_wdata = 32'h0000_0000;
    end
  end

  assign err = err_q;

  // A stalled cycle or an abandoned access writes a bubble into MEM/WB.
  assign bubble_s = freeze | ((state_q == S_DONE) & abandon_q);

  // MEM/WB next-state: load the EX/MEM op, or a bubble that holds the data fields
  always_comb begin
    wb_en_d    = wb_en_q;
    mem_r_en_d = mem_r_en_q;
    alu_res_d  = alu_res_q;
    dest_d     = dest_q;
    if (bubble_s) begin
      wb_en_d    = 1'b0;
      mem_r_en_d = 1'b0;
    end else begin
      wb_en_d    = ex_wb_en;
      mem_r_en_d = ex_mem_r_en;
      alu_res_d  = ex_alu_res;
      dest_d     = ex_dest;
    end
  end

  // MEM/WB register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_en_q    <= 1'b0;
      mem_r_en_q <= 1'b0;
      alu_res_q  <= 32'h0000_0000;
      dest_q     <= 4'h0;
    end else begin
      wb_en_q    <= wb_en_d;
      mem_r_en_q <= mem_r_en_d;
      alu_res_q  <= alu_res_d;
      dest_q     <= dest_d;
    end
  end

  // Writeback bus: loads take the buffered read data, everything else the ALU result
  always_comb begin
    WB_WB_EN = wb_en_q;
    WBDest   = dest_q;
    if (mem_r_en_q) begin
      WBValue = rdata_buf_q;
    end else begin
      WBValue = alu_res_q;
    end
  end

endmodule

// File: tb/tb_mem_wb_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_wb_unit
//
// Self-checking bench for mem_wb_unit. A table of per-cycle vectors covers
// reset, an ALU op, a 3-cycle-ack load and a 1-cycle-ack store; hand-written
// sequences cover the access timeout and a reset in the middle of an access.
// Inputs are driven 1 ns after the rising edge, outputs sampled 1 ns later.
// -----------------------------------------------------------------------------
module tb_mem_wb_unit;

  logic        clk;
  logic        rst;
  logic        ex_wb_en;
  logic        ex_mem_r_en;
  logic        ex_mem_w_en;
  logic [31:0] ex_alu_res;
  logic [31:0] ex_val_rm;
  logic [3:0]  ex_dest;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        freeze;
  logic        err;
  logic        WB_WB_EN;
  logic [3:0]  WBDest;
  logic [31:0] WBValue;

  int checks;
  int errors;

  mem_wb_unit #(
    .BASE_ADDR(1024),
    .TIMEOUT  (16),
    .CNT_W    (5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ex_wb_en   (ex_wb_en),
    .ex_mem_r_en(ex_mem_r_en),
    .ex_mem_w_en(ex_mem_w_en),
    .ex_alu_res (ex_alu_res),
    .ex_val_rm  (ex_val_rm),
    .ex_dest    (ex_dest),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .freeze     (freeze),
    .err        (err),
    .WB_WB_EN   (WB_WB_EN),
    .WBDest     (WBDest),
    .WBValue    (WBValue)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic        wb;
    logic        rd;
    logic        wr;
    logic [31:0] alu;
    logic [31:0] rm;
    logic [3:0]  dst;
    logic        ack;
    logic [31:0] rdata;
    logic        e_req;
    logic        e_frz;
    logic        e_err;
    logic        e_wbe;
    logic [3:0]  e_wbd;
    logic [31:0] e_wbv;
    logic        chkm;
    logic        e_we;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wb, input logic rd, input logic wr,
                       input logic [31:0] alu, input logic [31:0] rm,
                       input logic [3:0] dst, input logic ack, input logic [31:0] rdata);
    ex_wb_en    = wb;
    ex_mem_r_en = rd;
    ex_mem_w_en = wr;
    ex_alu_res  = alu;
    ex_val_rm   = rm;
    ex_dest     = dst;
    mem_ack     = ack;
    mem_rdata   = rdata;
  endtask

  task automatic chk_ctl(input string tag, input logic req, input logic frz, input logic er,
                         input logic wbe);
    chk({tag, " mem_req"},  {31'd0, mem_req},  {31'd0, req});
    chk({tag, " freeze"},   {31'd0, freeze},   {31'd0, frz});
    chk({tag, " err"},      {31'd0, err},      {31'd0, er});
    chk({tag, " WB_WB_EN"}, {31'd0, WB_WB_EN}, {31'd0, wbe});
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0);

    //           rst   wb    rd    wr    alu           rm            dst    ack   rdata          req   frz   err   wbe   wbd    wbv           chkm  we    addr       wdata
    vecs[0]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0408, 32'hAAAA_5555, 4'd7, 1'b1, 32'h1111_1111, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0,         1'b1, 1'b0, 32'd0, 32'h0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_040C, 32'h5A5A_5A5A, 4'd9, 1'b0, 32'h2222_2222, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0,         1'b1, 1'b0, 32'd0, 32'h0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         4'd0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0,         1'b0, 1'b0, 32'd0, 32'h0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         4'd0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0,         1'b0, 1'b0, 32'd0, 32'h0};
    // ALU op
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0010, 32'h0,         4'd3, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0,         1'b0, 1'b0, 32'd0, 32'h0};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         4'd0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 32'h0000_0010, 1'b0, 1'b0, 32'd0, 32'h0};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         4'd0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0,         1'b0, 1'b0, 32'd0, 32'h0};
    // LDR at 1032, ack on the 3rd BUSY cycle
    vecs[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'd1032,      32'h0,         4'd5, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 32'h0,         1'b0, 1'b0, 32'd0, 32'h0};
    vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'd1032,      32'h0,         4'd5, 1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 32'h0,         1'b1, 1'b0, 32'd2, 32'h0};
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'd1032,      32'h0,         4'd5, 1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 32'h0,         1'b1, 1'b0, 32'd2, 32'h0};
    vecs[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'd1032,      32'h0,         4'd5, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 32'h0,         1'b1, 1'b0, 32'd2, 32'h0};
    vecs[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'd1032,      32'h0,         4'd5, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0,         1'b0, 1'b0, 32'd0, 32'h0};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         4'd0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 4'd5, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'd0, 32'h0};
    // STR at 1036, 1-cycle ack
    vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'd1036,      32'h1234_5678, 4'd0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 32'h0,         1'b0, 1'b0, 32'd0, 32'h0};
    vecs[14] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'd1036,      32'h1234_5678, 4'd0, 1'b1, 32'h0,         1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 32'h0,         1'b1, 1'b1, 32'd3, 32'h1234_5678};
    vecs[15] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'd1036,      32'h1234_5678, 4'd0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0,         1'b0, 1'b0, 32'd0, 32'h0};
    vecs[16] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         4'd0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd1036,      1'b0, 1'b0, 32'd0, 32'h0};
    vecs[17] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         4'd0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0,         1'b0, 1'b0, 32'd0, 32'h0};

    for (int i = 0; i < NV; i++) begin
      string tag;
      cyc();
      rst = vecs[i].rst;
      drive(vecs[i].wb, vecs[i].rd, vecs[i].wr, vecs[i].alu, vecs[i].rm,
            vecs[i].dst, vecs[i].ack, vecs[i].rdata);
      #1;
      tag = $sformatf("row%0d", i);
      chk_ctl(tag, vecs[i].e_req, vecs[i].e_frz, vecs[i].e_err, vecs[i].e_wbe);
      chk({tag, " WBDest"},  {28'd0, WBDest}, {28'd0, vecs[i].e_wbd});
      chk({tag, " WBValue"}, WBValue, vecs[i].e_wbv);
      if (vecs[i].chkm) begin
        chk({tag, " mem_we"},    {31'd0, mem_we}, {31'd0, vecs[i].e_we});
        chk({tag, " mem_addr"},  mem_addr, vecs[i].e_addr);
        chk({tag, " mem_wdata"}, mem_wdata, vecs[i].e_wdata);
      end
    end

    // Timeout: load at 1056 (word 8) that is never acknowledged
    cyc();
    drive(1'b1, 1'b1, 1'b0, 32'd1056, 32'h0, 4'd9, 1'b0, 32'h0);
    #1;
    chk_ctl("to_detect", 1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 16; k++) begin
      cyc();
      #1;
      chk_ctl($sformatf("to_busy%0d", k), 1'b1, 1'b1, 1'b0, 1'b0);
      chk($sformatf("to_busy%0d mem_addr", k), mem_addr, 32'd8);
    end
    cyc();
    #1;
    chk_ctl("to_done", 1'b0, 1'b0, 1'b1, 1'b0);
    // Pipeline moves on: ALU op behind the abandoned load
    cyc();
    drive(1'b1, 1'b0, 1'b0, 32'h0000_0055, 32'h0, 4'd2, 1'b0, 32'h0);
    #1;
    chk_ctl("to_bubble", 1'b0, 1'b0, 1'b1, 1'b0);
    cyc();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0, 1'b0, 32'h0);
    #1;
    chk_ctl("to_alu", 1'b0, 1'b0, 1'b1, 1'b1);
    chk("to_alu WBDest", {28'd0, WBDest}, 32'd2);
    chk("to_alu WBValue", WBValue, 32'h0000_0055);

    // Reset during the 2nd BUSY cycle, then a stray ack
    cyc();
    drive(1'b1, 1'b1, 1'b0, 32'd1056, 32'h0, 4'd9, 1'b0, 32'h0);
    #1;
    chk_ctl("rb_detect", 1'b0, 1'b1, 1'b1, 1'b0);
    cyc();
    #1;
    chk_ctl("rb_busy1", 1'b1, 1'b1, 1'b1, 1'b0);
    cyc();
    #1;
    chk_ctl("rb_busy2", 1'b1, 1'b1, 1'b1, 1'b0);
    #1;
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0, 1'b0, 32'h0);
    #1;
    chk_ctl("rb_in_reset", 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    mem_ack   = 1'b1;
    mem_rdata = 32'hBAD0_BAD0;
    #1;
    chk_ctl("rb_ack_in_reset", 1'b0, 1'b0, 1'b0, 1'b0);
    cyc();
    #1;
    chk_ctl("rb_reset_edge", 1'b0, 1'b0, 1'b0, 1'b0);
    cyc();
    rst = 1'b1;
    #1;
    chk_ctl("rb_release", 1'b0, 1'b0, 1'b0, 1'b0);
    cyc();
    #1;
    chk_ctl("rb_stray_ack", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rb_stray_ack WBValue", WBValue, 32'h0);
    cyc();
    mem_ack = 1'b0;
    #1;
    chk_ctl("rb_idle", 1'b0, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_wb_unit.md
Name: mem_wb_unit

Overview:
- Memory-access and writeback end of the ARM pipeline.
- Takes EX/MEM results and performs LDR/STR through a req/ack data-memory handshake.
- Asserts `freeze` to stall the upstream stages (it drives the IF/ID `hazard` input) while an access is outstanding.
- Holds the MEM/WB register that drives the writeback bus (WB_WB_EN, WBDest, WBValue) consumed by the ID register file.

Parameters:
- BASE_ADDR, 1024: byte address subtracted from the ALU result before word addressing.
- TIMEOUT, 16: maximum BUSY cycles to wait for mem_ack before abandoning the access.
- CNT_W, 5: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- ex_wb_en  in  1  instruction writes a register.
- ex_mem_r_en  in  1  load.
- ex_mem_w_en  in  1  store.
- ex_alu_res  in  32  ALU result / byte address.
- ex_val_rm  in  32  store data.
- ex_dest  in  4  destination register.
- mem_ack  in  1  memory completed the access.
- mem_rdata  in  32  load data, valid with mem_ack.
- mem_req  out  1  access request.
- mem_we  out  1  1 = write.
- mem_addr  out  32  word address.
- mem_wdata  out  32  store data.
- freeze  out  1  stall upstream pipeline.
- err  out  1  sticky timeout flag.
- WB_WB_EN  out  1  register-file write enable.
- WBDest  out  4  write register.
- WBValue  out  32  write data.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, counter=0, err=0.
  - All MEM/WB register fields are 0, so WB_WB_EN=0, WBDest=0, WBValue=0.
  - mem_req=0, freeze=0.
  - Reset mid-access drops mem_req immediately; a late ack is ignored.
- memop = ex_mem_r_en | ex_mem_w_en. If both are set, the access is treated as a read.
- Upstream holds the ex_* inputs stable while freeze=1.
- FSM states IDLE, BUSY, DONE:
  - IDLE: if memop, next state is BUSY and the counter clears; otherwise stay in IDLE.
  - BUSY: mem_req=1.
    - mem_ack=1: latch mem_rdata into rdata_buf, next state is DONE.
    - Else, counter = TIMEOUT-1: set err, next state is DONE with abandon=1.
    - Else: increment the counter.
  - DONE: next state is always IDLE. A new access never starts from DONE; the held op is the one just completed.
- mem_ack outside BUSY is ignored.
- Memory-port outputs:
  - mem_we = ex_mem_w_en & ~ex_mem_r_en.
  - mem_addr = (ex_alu_res - BASE_ADDR) >> 2, a logical shift on a 32-bit result; wrap-around below BASE_ADDR is not checked.
  - mem_wdata = ex_val_rm.
  - mem_addr, mem_wdata and mem_we are combinational from the held inputs. They are only meaningful while mem_req=1.
- freeze = (IDLE & memop) | BUSY. It is combinational and deasserts in DONE.
- MEM/WB register, updated every rising edge:
  - freeze=1: load a bubble (wb_en=0, mem_r_en=0; other fields don't-care, hold).
  - freeze=0: load ex_wb_en, ex_mem_r_en, ex_alu_res, ex_dest.
  - Abandoned access in DONE: load a bubble instead.
- WB_WB_EN = registered wb_en.
- WBDest = registered dest.
- WBValue = registered mem_r_en ? rdata_buf : registered alu_res. This is a combinational mux from registers.
- Latency:
  - Non-memory op: visible on the WB bus the cycle after it is presented.
  - Memory op: detected in cycle 0, req from cycle 1, ack sampled at the end of cycle n, DONE in cycle n+1, WB bus valid in cycle n+2.
- Back-to-back memory ops: the second is detected in the IDLE cycle after DONE. Minimum spacing is 3 cycles per op for a 1-cycle ack.
- err is sticky until reset. The pipeline continues after a timeout.

Test Plan:
1. Reset: hold rst=0 with random inputs and toggling mem_ack -> all outputs 0, freeze=0. Release rst; it is still 0 until an op is presented.
2. ALU op: ex_wb_en=1, ex_dest=3, ex_alu_res=0x10, mem enables 0 -> next cycle WB_WB_EN=1, WBDest=3, WBValue=0x10; mem_req and freeze stay 0 throughout.
3. LDR: ex_mem_r_en=1, ex_wb_en=1, ex_alu_res=1032, ex_dest=5; ack on the 3rd BUSY cycle with mem_rdata=0xDEADBEEF:
   - mem_addr=2, mem_we=0, mem_req high for 3 cycles.
   - freeze high from detection through the ack cycle.
   - WB_WB_EN=0 during the stall.
   - Two cycles after the ack: WB_WB_EN=1, WBDest=5, WBValue=0xDEADBEEF.
4. STR: ex_mem_w_en=1, ex_alu_res=1036, ex_val_rm=0x12345678; 1-cycle ack -> mem_we=1, mem_addr=3, mem_wdata=0x12345678; WB_WB_EN stays 0; freeze low in DONE.
5. Timeout: LDR with mem_ack never asserted, TIMEOUT=16 -> mem_req high exactly 16 cycles, then err=1, freeze low, a bubble is written (WB_WB_EN=0), and err stays 1. A following ALU op completes normally.
6. Reset mid-BUSY: assert rst=0 during the 2nd BUSY cycle, then assert mem_ack while in reset -> mem_req=0 and freeze=0 immediately, err=0. After release the FSM is in IDLE and ignores the stray ack.
